imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
- Sequences the core's word-indexed instruction memory: holds the core in stall after reset while a byte-stream loader fills the memory, then hands read access to the core fetch path.
- Sits between the fetch stage (PC in, instruction out) and the 1024x32 instruction RAM. The RAM has a combinational read on word index and a synchronous write port owned by this block.
- Replaces file-preloaded instruction contents, so programs can be loaded on hardware and reloaded at runtime.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; must be a power of two.
- ADDR_W, 10, word-index width; equals log2(DEPTH).
- NOP_INSTR, 32'h00000013, instruction driven to the core while stalled (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted when ld_valid&&ld_ready.
- ld_byte  in  8  program byte, little-endian within each word.
- ld_last  in  1  qualifies the final byte of the image.
- ld_start  in  1  in RUN or ERR: restart loading from word 0.
- fetch_pc  in  32  core byte address.
- fetch_instr  out  32  instruction to the core.
- fetch_misalign  out  1  fetch_pc[1:0]!=0 while in RUN.
- core_stall  out  1  core must hold its PC and register state.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word index, for both read and write.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM combinational read data.
- load_done  out  1  one-cycle pulse on entry to RUN.
- load_err  out  1  sticky while in ERR (image overflowed DEPTH).
- words_loaded  out  ADDR_W+1  count of words written by the last load.

Behaviour:
- Reset (clk edge with rst=1):
  - state=LOAD; byte_cnt=0; word_ptr=0; shift register=0.
  - Outputs: mem_we=0, load_done=0, load_err=0, words_loaded=0.
  - core_stall=1, ld_ready=1, fetch_instr=NOP_INSTR.
  - rst mid-load abandons the partial image. RAM contents are not cleared.
- States: LOAD, FLUSH, RUN, ERR.
- LOAD:
  - ld_ready=1, core_stall=1.
  - Each accepted byte is placed at bits [8*byte_cnt+7 : 8*byte_cnt]; byte_cnt increments mod 4.
  - On the 4th byte, or on ld_last: register mem_we=1, mem_wdata=assembled word, mem_addr=word_ptr. The write is visible on the next cycle (1-cycle write latency). word_ptr then increments.
  - If ld_last arrives with byte_cnt<3, the missing upper bytes are zero-padded.
  - ld_last -> FLUSH.
  - A byte accepted when word_ptr==DEPTH -> ERR. No write is issued and the pointer does not wrap.
- FLUSH (1 cycle):
  - Completes the final registered write; ld_ready=0.
  - Next state RUN; words_loaded=word_ptr.
  - load_done pulses in the first RUN cycle.
- RUN:
  - core_stall=0, ld_ready=0, mem_we=0.
  - mem_addr=fetch_pc[ADDR_W+1:2]; fetch_instr=mem_rdata (combinational, zero latency).
  - Upper PC bits are ignored, so addresses alias modulo 4*DEPTH.
  - ld_start=1 -> LOAD next cycle, with word_ptr=0 and byte_cnt=0.
- ERR:
  - load_err=1, core_stall=1, ld_ready=0, fetch_instr=NOP_INSTR.
  - Exit only via ld_start (-> LOAD, load_err cleared) or rst.
- In LOAD, FLUSH and ERR: mem_addr=write pointer, fetch_misalign=0.
- ld_start is ignored in LOAD and FLUSH.
- ld_valid with ld_last=1 on an empty image (byte_cnt=0, word_ptr=0) writes one zero-padded word.
- A simultaneous last byte and overflow (word_ptr==DEPTH) -> ERR.

Decomposition:
- Shared package imem_pkg:
  - state enum {LOAD, FLUSH, RUN, ERR};
  - NOP_INSTR constant;
  - DEPTH/ADDR_W defaults, shared with the instruction RAM.
- Sub-module: imem_word_packer. Handles byte -> 32-bit assembly, byte_cnt and zero padding; outputs word_valid/word.

Test Plan:
- Reset, then stream 8 bytes 93,00,50,00,13,01,A0,00 with ld_last on the 8th:
  - mem writes 0x00500093@0 and 0x00A00113@1;
  - load_done pulses once; words_loaded=2;
  - fetch_pc=4 -> fetch_instr=0x00A00113.
- Stream 5 bytes 11,22,33,44,55 with last on the 5th -> words 0x44332211@0 and 0x00000055@1.
- Stall with gaps: ld_valid toggled every other cycle -> identical RAM contents; core_stall=1 and fetch_instr=0x00000013 throughout LOAD.
- Overflow with DEPTH=4: 17 bytes -> 4 writes, then ERR with load_err=1 and ld_ready=0. ld_start -> LOAD, load_err=0.
- In RUN, pulse ld_start and load 4 bytes -> word 0 rewritten, words_loaded=1. fetch_pc=2 -> fetch_misalign=1.
- Assert rst after 6 of 8 bytes -> state LOAD, word_ptr=0; a new 4-byte image writes @0.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory boot controller and the
// instruction RAM it fronts: default geometry, the stall instruction and the
// controller state encoding.
// ---------------------------------------------------------------------------
package imem_pkg;

    // Default RAM geometry: 1024 words of 32 bits, word-indexed.
    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;

    // addi x0,x0,0 -- harmless filler handed to the core while it is stalled.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // LOAD  : accepting loader bytes and writing words
    // FLUSH : one cycle to retire the final registered write
    // RUN   : core owns the read port
    // ERR   : image overflowed the RAM, waiting for a restart
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        ERR   = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// ---------------------------------------------------------------------------
// imem_word_packer
// Assembles a little-endian byte stream into 32-bit words.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear_i       drop any partial word and restart at byte 0
//   byte_valid_i  a byte is being consumed this cycle
//   byte_i        the byte
//   last_i        the byte closes the image; the word is emitted zero-padded
//   word_valid_o  word_o is complete this cycle (4th byte or last byte)
//   word_o        assembled word including the current byte
// ---------------------------------------------------------------------------
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  byteCnt_q;
    logic [31:0] shift_q;
    logic [31:0] assembled;

    // The partial word always has its not-yet-filled upper bytes at zero, so
    // OR-ing in the incoming byte also gives the zero padding for a short
    // final word.
    always_comb begin
        assembled    = shift_q | (32'(byte_i) << {byteCnt_q, 3'b000});
        word_valid_o = byte_valid_i && ((byteCnt_q == 2'd3) || last_i);
    end

    assign word_o = assembled;

    // Once a word is emitted the packer empties itself so the next word
    // starts clean at byte lane 0.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            byteCnt_q <= 2'd0;
            shift_q   <= 32'd0;
        end else if (byte_valid_i) begin
            if (word_valid_o) begin
                byteCnt_q <= 2'd0;
                shift_q   <= 32'd0;
            end else begin
                byteCnt_q <= byteCnt_q + 2'd1;
                shift_q   <= assembled;
            end
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl
// Owns the instruction RAM port. After reset the core is stalled while a
// byte-stream loader fills the RAM; once the image is complete the read port
// is handed to the fetch path. A new image can be loaded at runtime.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_byte   loader byte handshake
//   ld_last                     final byte of the image
//   ld_start                    restart loading from word 0 (RUN/ERR only)
//   fetch_pc/fetch_instr        core fetch interface
//   fetch_misalign              PC not word aligned while running
//   core_stall                  core must hold its state
//   mem_we/mem_addr/mem_wdata   RAM write port and shared word index
//   mem_rdata                   RAM combinational read data
//   load_done                   one-cycle pulse entering RUN
//   load_err                    high while in ERR (image too large)
//   words_loaded                words written by the last completed load
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int          DEPTH     = imem_pkg::IMEM_DEPTH,
    parameter int          ADDR_W    = imem_pkg::IMEM_ADDR_W,
    parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    input  logic              ld_start,
    input  logic [31:0]       fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              fetch_misalign,
    output logic              core_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    import imem_pkg::*;

    // The pointer is one bit wider than a RAM index so it can hold DEPTH,
    // meaning "RAM full" rather than wrapping back onto word 0.
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);

    imem_state_e       state_q, state_d;
    logic [ADDR_W:0]   wordPtr_q, wordPtr_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic              loadDone_q, loadDone_d;
    logic [ADDR_W:0]   wordsLoaded_q, wordsLoaded_d;

    logic        byteAccept;
    logic        ptrFull;
    logic        restart;
    logic        packValid;
    logic        wordValid;
    logic [31:0] packedWord;
    logic        running;
    logic        unusedPcHigh;

    assign running    = (state_q == RUN);
    assign byteAccept = (state_q == LOAD) && ld_valid;
    assign ptrFull    = (wordPtr_q == PTR_FULL);
    assign restart    = ld_start && ((state_q == RUN) || (state_q == ERR));
    // A byte arriving with the RAM already full never reaches the packer.
    assign packValid  = byteAccept && !ptrFull;

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (restart),
        .byte_valid_i (packValid),
        .byte_i       (ld_byte),
        .last_i       (ld_last),
        .word_valid_o (wordValid),
        .word_o       (packedWord)
    );

    // Next-state logic. Writes are registered: the word, its address and the
    // enable are captured here and presented to the RAM on the following
    // cycle, which is why FLUSH exists to let the final write land.
    always_comb begin
        state_d       = state_q;
        wordPtr_d     = wordPtr_q;
        memWe_d       = 1'b0;
        wrAddr_d      = wrAddr_q;
        memWdata_d    = memWdata_q;
        loadDone_d    = 1'b0;
        wordsLoaded_d = wordsLoaded_q;
        case (state_q)
            LOAD: begin
                if (byteAccept) begin
                    if (ptrFull) begin
                        state_d = ERR;
                    end else begin
                        if (wordValid) begin
                            memWe_d    = 1'b1;
                            wrAddr_d   = wordPtr_q[ADDR_W-1:0];
                            memWdata_d = packedWord;
                            wordPtr_d  = wordPtr_q + 1'b1;
                        end
                        if (ld_last) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                state_d       = RUN;
                wordsLoaded_d = wordPtr_q;
                loadDone_d    = 1'b1;
            end
            RUN, ERR: begin
                if (ld_start) begin
                    state_d   = LOAD;
                    wordPtr_d = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and registered write-port outputs. RAM contents are deliberately
    // left alone on reset; only the sequencing state is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            wordPtr_q     <= '0;
            memWe_q       <= 1'b0;
            wrAddr_q      <= '0;
            memWdata_q    <= 32'd0;
            loadDone_q    <= 1'b0;
            wordsLoaded_q <= '0;
        end else begin
            state_q       <= state_d;
            wordPtr_q     <= wordPtr_d;
            memWe_q       <= memWe_d;
            wrAddr_q      <= wrAddr_d;
            memWdata_q    <= memWdata_d;
            loadDone_q    <= loadDone_d;
            wordsLoaded_q <= wordsLoaded_d;
        end
    end

    // Outside RUN the index follows the write side: the address of the write
    // in flight, otherwise the next word to be written. In RUN the fetch PC
    // drives it directly; upper PC bits simply alias.
    always_comb begin
        if (running) begin
            mem_addr = fetch_pc[ADDR_W+1:2];
        end else if (memWe_q) begin
            mem_addr = wrAddr_q;
        end else begin
            mem_addr = wordPtr_q[ADDR_W-1:0];
        end
    end

    assign unusedPcHigh   = ^fetch_pc[31:ADDR_W+2];
    assign ld_ready       = (state_q == LOAD);
    assign core_stall     = !running;
    assign fetch_instr    = running ? mem_rdata : NOP_INSTR;
    assign fetch_misalign = running && (fetch_pc[1:0] != 2'b00);
    assign mem_we         = memWe_q;
    assign mem_wdata      = memWdata_q;
    assign load_done      = loadDone_q;
    assign load_err       = (state_q == ERR);
    assign words_loaded   = wordsLoaded_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_ctrl
// Self-checking bench for imem_boot_ctrl with a 4-word RAM so overflow is
// cheap to reach. Expected RAM writes and contents come from a byte-list
// model of the loader image.
// ---------------------------------------------------------------------------
module tb_imem_boot_ctrl;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef logic [7:0] byteQ_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_start;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_instr;
    logic              fetch_misalign;
    logic              core_stall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    logic [31:0] ram    [DEPTH];
    logic [31:0] refMem [DEPTH];
    wr_t         expWrites[$];

    int checkCount = 0;
    int passCount  = 0;

    imem_boot_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_byte        (ld_byte),
        .ld_last        (ld_last),
        .ld_start       (ld_start),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_misalign (fetch_misalign),
        .core_stall     (core_stall),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .load_done      (load_done),
        .load_err       (load_err),
        .words_loaded   (words_loaded)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction RAM: combinational read, synchronous write
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 32'd0;
            refMem[i] = 32'd0;
        end
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    endtask

    // Write monitor: every RAM write must match the next modelled write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (expWrites.size() == 0) begin
                checkOutput("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                wr_t w;
                w = expWrites.pop_front();
                checkOutput("write_addr", 32'(mem_addr), w.addr);
                checkOutput("write_data", mem_wdata, w.data);
            end
        end
    end

    // Image model: bytes fill words little-endian, a word is written after
    // every 4th byte or on the last byte (zero-padded), and a byte arriving
    // once DEPTH words are written overflows the image.
    function automatic bit modelLoad(input byteQ_t bytes, input bit lastSent, output int nWords);
        int          ptr = 0;
        int          cnt = 0;
        logic [31:0] cur = 32'd0;
        bit          ovf = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            if (ptr == DEPTH) begin
                ovf = 1'b1;
                break;
            end
            cur = cur | (32'(bytes[i]) << (8 * cnt));
            cnt++;
            if (cnt == 4 || (lastSent && i == bytes.size() - 1)) begin
                expWrites.push_back('{addr: 32'(ptr), data: cur});
                refMem[ptr] = cur;
                ptr++;
                cur = 32'd0;
                cnt = 0;
            end
        end
        nWords = ptr;
        return ovf;
    endfunction

    task automatic applyStimulus(input byteQ_t bytes, input bit lastOnFinal, input bit gaps, input bit noise);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                @(negedge clk);
                checkOutput("gap_stall", {31'd0, core_stall}, 32'd1);
            end
            if (noise) fetch_pc = $urandom;
            #1;
            checkOutput("load_ready", {31'd0, ld_ready}, 32'd1);
            checkOutput("load_stall", {31'd0, core_stall}, 32'd1);
            checkOutput("load_nop", fetch_instr, NOP);
            checkOutput("load_misalign", {31'd0, fetch_misalign}, 32'd0);
            ld_valid = 1'b1;
            ld_byte  = bytes[i];
            ld_last  = lastOnFinal && (i == bytes.size() - 1);
            ld_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
    endtask

    task automatic startLoad();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        checkOutput("start_ready", {31'd0, ld_ready}, 32'd1);
        checkOutput("start_err", {31'd0, load_err}, 32'd0);
        checkOutput("start_stall", {31'd0, core_stall}, 32'd1);
    endtask

    task automatic finishLoad(input int nWords);
        int pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (load_done === 1'b1) pulses++;
        end
        checkOutput("load_done_pulses", 32'(pulses), 32'd1);
        checkOutput("words_loaded", 32'(words_loaded), 32'(nWords));
        checkOutput("run_stall", {31'd0, core_stall}, 32'd0);
        checkOutput("run_ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("run_err", {31'd0, load_err}, 32'd0);
    endtask

    // Read every word through the fetch path with random aliasing upper bits
    task automatic checkMem();
        for (int w = 0; w < DEPTH; w++) begin
            fetch_pc = ($urandom() << (ADDR_W + 2)) | 32'(w << 2);
            #1;
            checkOutput("fetch_word", fetch_instr, refMem[w]);
            checkOutput("fetch_aligned", {31'd0, fetch_misalign}, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic expectErr();
        checkOutput("err_flag", {31'd0, load_err}, 32'd1);
        checkOutput("err_ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("err_stall", {31'd0, core_stall}, 32'd1);
        checkOutput("err_nop", fetch_instr, NOP);
        checkOutput("err_misalign", {31'd0, fetch_misalign}, 32'd0);
        // Bytes offered in ERR must be ignored and the flag must stick
        ld_valid = 1'b1;
        ld_byte  = 8'($urandom);
        @(negedge clk);
        ld_valid = 1'b0;
        checkOutput("err_sticky", {31'd0, load_err}, 32'd1);
    endtask

    task automatic runGood(input byteQ_t bytes, input bit gaps, input bit noise);
        int n;
        bit ovf;
        ovf = modelLoad(bytes, 1'b1, n);
        applyStimulus(bytes, 1'b1, gaps, noise);
        finishLoad(n);
        checkMem();
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        byteQ_t q;
        int     n;
        int     len;
        bit     ovf;
        bit     lastBit;

        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_byte  = 8'd0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
        fetch_pc = 32'h2;
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_stall", {31'd0, core_stall}, 32'd1);
        checkOutput("rst_ready", {31'd0, ld_ready}, 32'd1);
        checkOutput("rst_nop", fetch_instr, NOP);
        checkOutput("rst_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_err", {31'd0, load_err}, 32'd0);
        checkOutput("rst_words", 32'(words_loaded), 32'd0);
        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
        rst = 1'b0;

        $display("[TB] two-word program");
        q = {8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        runGood(q, 1'b0, 1'b0);
        fetch_pc = 32'd4;
        #1;
        checkOutput("prog_pc4", fetch_instr, 32'h00A0_0113);
        fetch_pc = 32'd0;
        #1;
        checkOutput("prog_pc0", fetch_instr, 32'h0050_0093);
        @(negedge clk);

        $display("[TB] short final word");
        startLoad();
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        runGood(q, 1'b0, 1'b0);
        fetch_pc = 32'd4;
        #1;
        checkOutput("pad_word1", fetch_instr, 32'h0000_0055);
        @(negedge clk);

        $display("[TB] same image with gaps");
        startLoad();
        runGood(q, 1'b1, 1'b0);

        $display("[TB] overflow with last on the overflowing byte");
        startLoad();
        q = {};
        for (int k = 0; k < 4 * DEPTH + 1; k++) q.push_back(8'($urandom));
        ovf = modelLoad(q, 1'b1, n);
        applyStimulus(q, 1'b1, 1'b0, 1'b0);
        expectErr();
        startLoad();
        q = {8'hDE, 8'hAD};
        runGood(q, 1'b0, 1'b0);

        $display("[TB] runtime reload of one word");
        startLoad();
        q = {8'h01, 8'h02, 8'h03, 8'h04};
        runGood(q, 1'b0, 1'b0);
        fetch_pc = 32'd2;
        #1;
        checkOutput("misalign_pc2", {31'd0, fetch_misalign}, 32'd1);
        fetch_pc = 32'd0;
        #1;
        checkOutput("reload_word0", fetch_instr, 32'h0403_0201);
        @(negedge clk);

        $display("[TB] reset mid-load");
        startLoad();
        q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        ovf = modelLoad(q, 1'b0, n);
        applyStimulus(q, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ready", {31'd0, ld_ready}, 32'd1);
        checkOutput("midrst_words", 32'(words_loaded), 32'd0);
        checkOutput("midrst_stall", {31'd0, core_stall}, 32'd1);
        q = {8'h37, 8'h05, 8'h00, 8'h10};
        runGood(q, 1'b0, 1'b0);

        $display("[TB] randomized images");
        for (int it = 0; it < 25; it++) begin
            startLoad();
            if ($urandom_range(0, 3) == 0) begin
                q = {};
                for (int k = 0; k < 4 * DEPTH + 1; k++) q.push_back(8'($urandom));
                lastBit = 1'($urandom_range(0, 1));
                ovf = modelLoad(q, lastBit, n);
                applyStimulus(q, lastBit, 1'($urandom_range(0, 1)), 1'b1);
                expectErr();
                startLoad();
            end
            len = $urandom_range(1, 4 * DEPTH);
            q = {};
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            runGood(q, 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (2) @(negedge clk);
        checkOutput("pending_writes", 32'(expWrites.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
